// File: rtl/div16by8_seq.sv
// Iterative unsigned restoring divider: N-bit dividend / D-bit divisor.
// One quotient bit per clock, with registered results and a one-cycle done pulse.
module div16by8_seq #(
    parameter int N = 16,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] X,
    input  logic [D-1:0] Y,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Q,
    output logic [D-1:0] R,
    output logic         dz
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   dvd_q, dvd_d;
    logic [D-1:0]   dvs_q, dvs_d;
    logic [D:0]     rem_q, rem_d;
    logic [N-1:0]   quo_q, quo_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [N-1:0]   q_q, q_d;
    logic [D-1:0]   r_q, r_d;
    logic           dz_q, dz_d;

    logic [D:0]     rem_shift_s;
    logic [D:0]     rem_sub_s;
    logic           ge_s;
    logic [D:0]     rem_nxt_s;
    logic [N-1:0]   quo_nxt_s;

    // One restoring step: shift in the dividend MSB, subtract when it fits.
    assign rem_shift_s = {rem_q[D-1:0], dvd_q[N-1]};
    assign ge_s        = (rem_shift_s >= {1'b0, dvs_q});
    assign rem_sub_s   = rem_shift_s - {1'b0, dvs_q};
    assign rem_nxt_s   = ge_s ? rem_sub_s : rem_shift_s;
    assign quo_nxt_s   = {quo_q[N-2:0], ge_s};

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    dvd_d   = X;
                    dvs_d   = Y;
                    rem_d   = {(D+1){1'b0}};
                    quo_d   = {N{1'b0}};
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                dvd_d = {dvd_q[N-2:0], 1'b0};
                rem_d = rem_nxt_s;
                quo_d = quo_nxt_s;
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_DONE;
                    dz_d    = (dvs_q == {D{1'b0}});
                    // A zero divisor shifts X's low bits into the remainder untouched.
                    if (dvs_q == {D{1'b0}}) begin
                        q_d = {N{1'b1}};
                        r_d = rem_nxt_s[D-1:0];
                    end else begin
                        q_d = quo_nxt_s;
                        r_d = rem_nxt_s[D-1:0];
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State, working and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dvd_q   <= {N{1'b0}};
            dvs_q   <= {D{1'b0}};
            rem_q   <= {(D+1){1'b0}};
            quo_q   <= {N{1'b0}};
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= {N{1'b0}};
            r_q     <= {D{1'b0}};
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Q    = q_q;
    assign R    = r_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_div16by8_seq.sv
// Bench for div16by8_seq: directed cases, reset abort, ignored start, and
// randomized back-to-back operations checked against integer division.
module tb_div16by8_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] X;
    logic [7:0]  Y;
    logic        busy;
    logic        done;
    logic [15:0] Q;
    logic [7:0]  R;
    logic        dz;

    int checks = 0;
    int errors = 0;

    logic [15:0] last_q;
    logic [7:0]  last_r;
    logic        last_dz;

    div16by8_seq #(.N(16), .D(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .X(X), .Y(Y),
        .busy(busy), .done(done), .Q(Q), .R(R), .dz(dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present an operation; returns 1ns after the accepting edge.
    task automatic issue(input logic [15:0] x, input logic [7:0] y);
        start = 1'b1;
        X = x;
        Y = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        X = 16'($urandom);
        Y = 8'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("done_after_accept", 32'(done), 32'd0);
        chk("q_hold_on_accept", 32'(Q), 32'(last_q));
    endtask

    // Follow the N run edges; inj > 0 pulses a stray start after that edge.
    task automatic finish_op(input logic [15:0] x, input logic [7:0] y, input int inj);
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ez;
        ez = (y == 8'd0);
        eq = ez ? 16'hFFFF : x / {8'd0, y};
        er = ez ? x[7:0] : 8'(x % {8'd0, y});
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            if (i < 16) begin
                chk("busy_in_run", 32'(busy), 32'd1);
                chk("no_early_done", 32'(done), 32'd0);
                chk("q_hold_in_run", 32'(Q), 32'(last_q));
                chk("r_hold_in_run", 32'(R), 32'(last_r));
                chk("dz_hold_in_run", 32'(dz), 32'(last_dz));
            end else begin
                chk("done_at_latency", 32'(done), 32'd1);
                chk("busy_off_at_done", 32'(busy), 32'd0);
                chk("quotient", 32'(Q), 32'(eq));
                chk("remainder", 32'(R), 32'(er));
                chk("dz_flag", 32'(dz), 32'(ez));
                if (!ez) begin
                    chk("product_identity", 32'(Q) * 32'(y) + 32'(R), 32'(x));
                    chk("rem_below_divisor", 32'(R < y), 32'd1);
                end
                last_q  = eq;
                last_r  = er;
                last_dz = ez;
            end
            if (i == inj) begin
                start = 1'b1;
                X = 16'd9;
                Y = 8'd3;
            end
            if (i == inj + 1) start = 1'b0;
        end
    endtask

    task automatic idle_step();
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("q_hold_idle", 32'(Q), 32'(last_q));
    endtask

    initial begin
        logic [15:0] rx;
        logic [7:0]  ry;
        rst_n = 1'b1;
        start = 1'b0;
        X = 16'd0;
        Y = 8'd0;
        last_q = 16'd0;
        last_r = 8'd0;
        last_dz = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_q", 32'(Q), 32'd0);
        chk("reset_r", 32'(R), 32'd0);
        chk("reset_dz", 32'(dz), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        issue(16'd200, 8'd7);     finish_op(16'd200, 8'd7, 0);     idle_step();
        issue(16'd65535, 8'd255); finish_op(16'd65535, 8'd255, 0); idle_step();
        issue(16'd5, 8'd9);       finish_op(16'd5, 8'd9, 0);       idle_step();
        issue(16'd0, 8'd1);       finish_op(16'd0, 8'd1, 0);       idle_step();
        issue(16'h1234, 8'd0);    finish_op(16'h1234, 8'd0, 0);    idle_step();
        issue(16'd100, 8'd10);    finish_op(16'd100, 8'd10, 0);    idle_step();
        issue(16'd1000, 8'd3);    finish_op(16'd1000, 8'd3, 5);    idle_step();

        // Abort mid-run with reset: outputs clear at once and no done follows.
        issue(16'd1000, 8'd3);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_q", 32'(Q), 32'd0);
        chk("abort_r", 32'(R), 32'd0);
        chk("abort_dz", 32'(dz), 32'd0);
        last_q = 16'd0;
        last_r = 8'd0;
        last_dz = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", 32'(done), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("post_abort_idle", 32'(busy | done), 32'd0);
        end
        issue(16'd54321, 8'd123); finish_op(16'd54321, 8'd123, 0);

        // Back-to-back: each new start is presented during the DONE cycle.
        for (int k = 0; k < 200; k++) begin
            rx = 16'($urandom);
            ry = 8'($urandom_range(255, 0));
            if (k % 50 != 7 && ry == 8'd0) ry = 8'd1;
            issue(rx, ry);
            finish_op(rx, ry, 0);
        end
        for (int yv = 1; yv < 256; yv++) begin
            rx = (yv % 3 == 0) ? 16'hFFFF : 16'($urandom);
            ry = 8'(yv);
            issue(rx, ry);
            finish_op(rx, ry, 0);
        end
        idle_step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
